// File: rtl/if_prefetch_if.sv
// Fetch-side bus of the prefetch front end: instruction-memory port, redirect
// request and the valid/ready instruction stream towards decode.
interface if_prefetch_if #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 12,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   imem_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [CNT_W-1:0]       count;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_pc, out_instr, count,
        input  out_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_pc, out_instr, count,
        output out_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, reads a 1-cycle-latency
// instruction memory and buffers words in a first-word-fall-through queue.
module if_prefetch #(
    parameter int                    PC_WIDTH    = 12,
    parameter int                    INSTR_WIDTH = 12,
    parameter int                    DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          reset,
    if_prefetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    req_pc_p1;
    logic                   vld_p1;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic [CNT_W:0]         occupancy;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [PC_WIDTH-1:0]    addr;

    // An outstanding request already owns a slot, so issue never overruns the queue.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(vld_p1);
    assign issue     = reset & (bus.redirect | (occupancy < (CNT_W + 1)'(DEPTH)));
    assign addr      = bus.redirect ? bus.redirect_pc : fetch_pc;
    assign push      = vld_p1 & ~bus.redirect;
    assign pop       = bus.out_valid & bus.out_ready & ~bus.redirect;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = addr;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr] : '0;
    assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : '0;
    assign bus.count     = count;

    // Stage p0 -> p1: request issue and queue control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                fetch_pc <= addr + 1'b1;
            end
            if (bus.redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Datapath: the request PC and queue storage carry no reset; vld_p1 and count qualify them.
    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc_p1 <= addr;
        end
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc_p1;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios plus random
// ready/redirect traffic, checked by a scoreboard against a sequential-PC model.
module tb_if_prefetch;
    localparam int PW    = 12;
    localparam int IW    = 12;
    localparam int DEPTH = 4;
    localparam logic [PW-1:0] RST_PC = 12'h000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [PW-1:0] exp_q [$];
    logic          hold_prev = 1'b0;
    logic [PW-1:0] prev_pc;
    logic [IW-1:0] prev_instr;

    if_prefetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    if_prefetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: 1-cycle read latency, content = addr ^ A5A.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= bus.imem_addr ^ 12'hA5A;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // After reset or redirect to pc, the decode stream is pc, pc+1, ... (mod 2^PW).
    task automatic sb_restart(input logic [PW-1:0] pc);
        logic [PW-1:0] p;
        p = pc;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(p);
            p = p + 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        step();
        reset = 1'b0;
        bus.redirect = 1'b0;
        bus.out_ready = ready;
        sb_restart(RST_PC);
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_imem_en", bus.imem_en, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_instr", bus.out_instr, 0);
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_count3();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (bus.count == 3) hit = 1'b1;
        end
        check("reach_count3", {31'b0, hit}, 1);
    endtask

    task automatic do_redirect(input logic [PW-1:0] pc);
        bus.redirect = 1'b1;
        bus.redirect_pc = pc;
        sb_restart(pc);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            hold_prev <= 1'b0;
        end else begin
            check("count_le_depth", {31'b0, bus.count <= DEPTH}, 1);
            if (hold_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_pc", bus.out_pc, prev_pc);
                check("stall_instr", bus.out_instr, prev_instr);
            end
            if (bus.out_valid && bus.out_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", bus.out_pc, 12'hFFF + 1);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", bus.out_pc, e);
                    check("sb_instr", bus.out_instr, e ^ 12'hA5A);
                end
            end
            hold_prev  <= bus.out_valid && !bus.out_ready && !bus.redirect;
            prev_pc    <= bus.out_pc;
            prev_instr <= bus.out_instr;
        end
    end

    initial begin
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;

        // Reset release and streaming
        do_reset(1'b1);
        #2;
        check("t1_c0_imem_en", bus.imem_en, 1);
        check("t1_c0_addr", bus.imem_addr, 0);
        check("t1_c0_valid", bus.out_valid, 0);
        step(); #2;
        check("t1_c1_valid", bus.out_valid, 0);
        for (int k = 0; k < 8; k++) begin
            step(); #2;
            check("t1_valid", bus.out_valid, 1);
            check("t1_pc", bus.out_pc, k);
        end

        // Stall from cycle 0 then release with no gap
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) step();
        #2;
        check("t2_count", bus.count, DEPTH);
        check("t2_imem_en", bus.imem_en, 0);
        check("t2_out_pc", bus.out_pc, 0);
        step();
        bus.out_ready = 1'b1;
        #2;
        for (int k = 0; k < 7; k++) begin
            check("t2_nogap_valid", bus.out_valid, 1);
            check("t2_nogap_pc", bus.out_pc, k);
            step(); #2;
        end

        // Redirect with 3 queued and 1 in flight
        do_reset(1'b0);
        wait_count3();
        do_redirect(12'h0F0);
        #2;
        check("t3_imem_en", bus.imem_en, 1);
        check("t3_imem_addr", bus.imem_addr, 12'h0F0);
        step();
        bus.redirect = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check("t3_count0", bus.count, 0);
        check("t3_r1_valid", bus.out_valid, 0);
        step(); #2;
        check("t3_r2_valid", bus.out_valid, 1);
        check("t3_r2_pc", bus.out_pc, 12'h0F0);
        for (int k = 0; k < 3; k++) step();

        // Redirect coinciding with a handshake
        #2;
        check("t4_pre_valid", bus.out_valid, 1);
        step();
        do_redirect(12'h100);
        step();
        bus.redirect = 1'b0;
        #2;
        check("t4_count0", bus.count, 0);
        check("t4_valid0", bus.out_valid, 0);
        step(); #2;
        check("t4_first_pc", bus.out_pc, 12'h100);

        // Wrap from FFE
        step();
        do_redirect(12'hFFE);
        step();
        bus.redirect = 1'b0;
        step(); #2;
        check("t5_pc0", bus.out_pc, 12'hFFE);
        step(); #2;
        check("t5_pc1", bus.out_pc, 12'hFFF);
        step(); #2;
        check("t5_pc2", bus.out_pc, 12'h000);
        step(); #2;
        check("t5_pc3", bus.out_pc, 12'h001);

        // Asynchronous reset mid-operation
        do_reset(1'b0);
        wait_count3();
        #1;
        reset = 1'b0;
        sb_restart(RST_PC);
        #1;
        check("t6_async_valid", bus.out_valid, 0);
        check("t6_async_count", bus.count, 0);
        check("t6_async_imem_en", bus.imem_en, 0);
        step();
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        check("t6_refetch_en", bus.imem_en, 1);
        check("t6_refetch_addr", bus.imem_addr, RST_PC);
        step(); step(); #2;
        check("t6_first_pc", bus.out_pc, RST_PC);

        // Random ready/redirect traffic
        begin
            int since;
            since = 0;
            for (int c = 0; c < 1500; c++) begin
                step();
                bus.out_ready = ($urandom_range(0, 3) != 0);
                since++;
                if ($urandom_range(0, 23) == 0 || since >= 100) begin
                    logic [PW-1:0] t;
                    t = PW'($urandom);
                    if ($urandom_range(0, 3) == 0) t = 12'hFFC | PW'($urandom_range(0, 3));
                    do_redirect(t);
                    since = 0;
                end else begin
                    bus.redirect = 1'b0;
                end
            end
            step();
            bus.redirect = 1'b0;
            for (int c = 0; c < 10; c++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
